// File: rtl/alu_serial.sv
// -----------------------------------------------------------------------------
// alu_serial -- digit-serial ALU.
//
// Latches two WIDTH-bit operands and an operation code on an accepted start.
// It then evaluates the operands DIGIT bits per cycle, LSB first, through a
// DIGIT-wide slice that keeps its carry in a register. After the last digit
// it publishes a registered result plus zero / carry-out / overflow flags
// with a one-cycle done pulse. Throughput is one result per WIDTH/DIGIT + 2
// cycles.
//
// Parameters
//   WIDTH        operand / result width
//   DIGIT        bits processed per cycle (must divide WIDTH)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   abort        (ALU_SERIAL_ABORT_EN only) cancel a running operation
//   src1, src2   operands A and B, latched when start is accepted
//   ALU_control  operation code, latched when start is accepted
//   busy         high while running and during the done cycle
//   done         one-cycle pulse; result and flags are valid
//   result       registered result, held until the next accepted start
//   zero         result == 0 (valid operation codes only)
//   cout         carry out of the MSB (ADD/SUB only)
//   overflow     signed overflow (ADD/SUB only)
//
// Configuration macro
//   ALU_SERIAL_ABORT_EN  when defined, adds the abort input port.
// -----------------------------------------------------------------------------
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ALU_SERIAL_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;        // operand A, shifted right one digit per cycle
    logic [WIDTH-1:0]  b_q;        // operand B, shifted right one digit per cycle
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  res_q;      // result shift register, filled from the MSB side
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              zero_q;
    logic              cout_q;
    logic              ovf_q;

    // Abort request seen by the FSM; tied off when the feature is not built.
    logic abort_hit;
`ifdef ALU_SERIAL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Operation decode on the latched code
    // ------------------------------------------------------------------
    logic is_addsub;   // ADD or SUB: the only codes that report cout/overflow
    logic is_arith;    // ADD, SUB or SLT: uses the carry chain
    logic invert_b;    // SUB and SLT add ~B with carry-in 1
    logic valid_op;

    always_comb begin
        is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
        is_arith  = is_addsub || (op_q == OP_SLT);
        invert_b  = (op_q == OP_SUB) || (op_q == OP_SLT);
        valid_op  = is_arith || (op_q == OP_AND) || (op_q == OP_OR) ||
                    (op_q == OP_NOR) || (op_q == OP_NAND);
    end

    // ------------------------------------------------------------------
    // DIGIT-wide slice: low DIGIT bits of the operand registers plus carry_q
    // ------------------------------------------------------------------
    logic [DIGIT-1:0] dig_res;
    logic             carry_d;      // carry out of the digit
    logic             carry_top;    // carry into the top bit of the digit
    logic             a_bit;
    logic             b_bit;
    logic             b_eff;
    logic             c_run;

    // NOTE: every signal written in always_comb gets a default at the top of
    // the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        dig_res   = '0;
        c_run     = carry_q;
        carry_top = carry_q;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        b_eff     = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            a_bit     = a_q[i];
            b_bit     = b_q[i];
            b_eff     = b_bit ^ invert_b;
            // Ends the loop holding the carry into bit DIGIT-1; on the last
            // digit that is the carry into the operand MSB.
            carry_top = c_run;
            if (is_arith) begin
                dig_res[i] = a_bit ^ b_eff ^ c_run;
                c_run      = (a_bit & b_eff) | (c_run & (a_bit ^ b_eff));
            end else begin
                case (op_q)
                    OP_AND:  dig_res[i] = a_bit & b_bit;
                    OP_OR:   dig_res[i] = a_bit | b_bit;
                    OP_NOR:  dig_res[i] = ~a_bit & ~b_bit;
                    OP_NAND: dig_res[i] = ~a_bit | ~b_bit;
                    default: dig_res[i] = 1'b0;
                endcase
            end
        end
        carry_d = c_run;
    end

    // ------------------------------------------------------------------
    // Result shift and finalisation values (used on the last digit)
    // ------------------------------------------------------------------
    logic [WIDTH+DIGIT-1:0] shift_cat;
    logic [WIDTH-1:0]       res_shift;
    logic                   ovf_raw;
    logic [WIDTH-1:0]       final_res;

    always_comb begin
        shift_cat = {dig_res, res_q};
        res_shift = shift_cat[WIDTH+DIGIT-1:DIGIT];
        ovf_raw   = carry_top ^ carry_d;
        // SLT: sign of A-B corrected by signed overflow.
        if (op_q == OP_SLT) begin
            final_res = WIDTH'(dig_res[DIGIT-1] ^ ovf_raw);
        end else begin
            final_res = res_shift;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so that
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        a_q     <= src1;
                        b_q     <= src2;
                        op_q    <= ALU_control;
                        carry_q <= (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
                        cnt_q   <= '0;
                        res_q   <= '0;
                        zero_q  <= 1'b0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (abort_hit) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        zero_q  <= 1'b0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        a_q     <= a_q >> DIGIT;
                        b_q     <= b_q >> DIGIT;
                        carry_q <= carry_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_DIGIT) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            res_q    <= final_res;
                            // Unknown codes report every flag as 0, zero included.
                            zero_q   <= valid_op && (final_res == '0);
                            cout_q   <= is_addsub & carry_d;
                            ovf_q    <= is_addsub & ovf_raw;
                        end else begin
                            res_q    <= res_shift;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = res_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// -----------------------------------------------------------------------------
// tb_alu_serial -- directed self-checking bench for alu_serial.
// Two instances: dut1 (WIDTH=32, DIGIT=1) and dut4 (WIDTH=32, DIGIT=4).
// -----------------------------------------------------------------------------
module tb_alu_serial;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic clk = 1'b0;
    logic rst_n;

    logic        s1_start, s1_busy, s1_done, s1_zero, s1_cout, s1_ovf;
    logic [31:0] s1_a, s1_b, s1_res;
    logic [3:0]  s1_op;
    logic        s4_start, s4_busy, s4_done, s4_zero, s4_cout, s4_ovf;
    logic [31:0] s4_a, s4_b, s4_res;
    logic [3:0]  s4_op;
`ifdef ALU_SERIAL_ABORT_EN
    logic        s1_abort;
    logic        s4_abort;
`endif

    int passed = 0;
    int total  = 0;
    logic busy_at1;   // busy seen in the first cycle after acceptance

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(32), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start),
`ifdef ALU_SERIAL_ABORT_EN
        .abort(s1_abort),
`endif
        .src1(s1_a), .src2(s1_b), .ALU_control(s1_op),
        .busy(s1_busy), .done(s1_done), .result(s1_res),
        .zero(s1_zero), .cout(s1_cout), .overflow(s1_ovf)
    );

    alu_serial #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
`ifdef ALU_SERIAL_ABORT_EN
        .abort(s4_abort),
`endif
        .src1(s4_a), .src2(s4_b), .ALU_control(s4_op),
        .busy(s4_busy), .done(s4_done), .result(s4_res),
        .zero(s4_zero), .cout(s4_cout), .overflow(s4_ovf)
    );

    // Launch one operation on dut1 (wide=0) or dut4 (wide=1) and wait for
    // done. Operand inputs are scrambled after acceptance; if poke_at > 0 a
    // stray start is driven in that cycle of the run.
    task automatic do_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int poke_at,
                         output logic [31:0] res, output logic z, output logic c,
                         output logic v, output int lat);
        @(negedge clk);
        if (wide) begin s4_start = 1'b1; s4_a = a; s4_b = b; s4_op = op; end
        else      begin s1_start = 1'b1; s1_a = a; s1_b = b; s1_op = op; end
        @(posedge clk);
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy_at1 = wide ? s4_busy : s1_busy;
            s1_start = 1'b0;
            s4_start = 1'b0;
            if (wide) begin s4_a = ~a; s4_b = ~b; s4_op = OP_OR; end
            else      begin s1_a = ~a; s1_b = ~b; s1_op = OP_OR; end
            if (lat == poke_at) begin
                if (wide) begin s4_start = 1'b1; s4_a = 32'h0; s4_b = 32'h0; end
                else      begin s1_start = 1'b1; s1_a = 32'h0; s1_b = 32'h0; end
            end
            if ((wide ? s4_done : s1_done) === 1'b1) break;
        end
        res = wide ? s4_res  : s1_res;
        z   = wide ? s4_zero : s1_zero;
        c   = wide ? s4_cout : s1_cout;
        v   = wide ? s4_ovf  : s1_ovf;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({s1_busy, s1_done, s1_res, s1_zero, s1_cout, s1_ovf} !== 37'h0) begin
            $display("FAIL reset_dut1 got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                     s1_busy, s1_done, s1_res, s1_zero, s1_cout, s1_ovf);
        end else passed++;
        total++;
        if ({s4_busy, s4_done, s4_res, s4_zero, s4_cout, s4_ovf} !== 37'h0) begin
            $display("FAIL reset_dut4 got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                     s4_busy, s4_done, s4_res, s4_zero, s4_cout, s4_ovf);
        end else passed++;
    endtask

    task automatic test_add();
        logic [31:0] res; logic z, c, v; int lat;
        do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, -1, res, z, c, v, lat);
        total++;
        if (busy_at1 !== 1'b1) $display("FAIL add_busy_run got %b want 1", busy_at1);
        else passed++;
        total++;
        if (lat != 33) $display("FAIL add_latency got %0d want 33", lat);
        else passed++;
        total++;
        if ({res, z, c, v} !== {32'h8000_0000, 1'b0, 1'b0, 1'b1})
            $display("FAIL add_result got res=%h z=%b c=%b v=%b want res=80000000 z=0 c=0 v=1",
                     res, z, c, v);
        else passed++;
        @(negedge clk);
        total++;
        if ({s1_done, s1_busy, s1_res} !== {1'b0, 1'b0, 32'h8000_0000})
            $display("FAIL add_pulse got done=%b busy=%b res=%h want done=0 busy=0 res=80000000",
                     s1_done, s1_busy, s1_res);
        else passed++;
    endtask

    task automatic test_sub_nor();
        logic [31:0] res; logic z, c, v; int lat;
        do_op(1'b0, 32'h0000_0005, 32'h0000_0005, OP_SUB, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h0, 1'b1, 1'b1, 1'b0})
            $display("FAIL sub_equal got res=%h z=%b c=%b v=%b want res=0 z=1 c=1 v=0", res, z, c, v);
        else passed++;
        do_op(1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, OP_NOR, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL nor got res=%h z=%b c=%b v=%b want res=0 z=1 c=0 v=0", res, z, c, v);
        else passed++;
        do_op(1'b0, 32'hFFFF_0000, 32'hFF00_FF00, OP_NAND, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h00FF_FFFF, 1'b0, 1'b0, 1'b0})
            $display("FAIL nand got res=%h z=%b c=%b v=%b want res=00ffffff z=0 c=0 v=0", res, z, c, v);
        else passed++;
    endtask

    task automatic test_slt();
        logic [31:0] res; logic z, c, v; int lat;
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h1, 1'b0, 1'b0, 1'b0})
            $display("FAIL slt_neg got res=%h z=%b c=%b v=%b want res=1 z=0 c=0 v=0", res, z, c, v);
        else passed++;
        do_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, OP_SLT, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL slt_ovf got res=%h z=%b c=%b v=%b want res=0 z=1 c=0 v=0", res, z, c, v);
        else passed++;
    endtask

    task automatic test_bad_code();
        logic [31:0] res; logic z, c, v; int lat;
        do_op(1'b0, 32'hFFFF_FFFF, 32'h1234_5678, OP_BAD, -1, res, z, c, v, lat);
        total++;
        if (lat != 33) $display("FAIL bad_latency got %0d want 33", lat);
        else passed++;
        total++;
        if ({res, z, c, v} !== {32'h0, 1'b0, 1'b0, 1'b0})
            $display("FAIL bad_code got res=%h z=%b c=%b v=%b want all 0", res, z, c, v);
        else passed++;
    endtask

    task automatic test_digit4();
        logic [31:0] res; logic z, c, v; int lat;
        do_op(1'b1, 32'h0FFF_FFFF, 32'h0000_0001, OP_ADD, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h1000_0000, 1'b0, 1'b0, 1'b0})
            $display("FAIL d4_add_chain got res=%h z=%b c=%b v=%b want res=10000000 z=0 c=0 v=0",
                     res, z, c, v);
        else passed++;
        do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h0, 1'b1, 1'b1, 1'b0})
            $display("FAIL d4_add_wrap got res=%h z=%b c=%b v=%b want res=0 z=1 c=1 v=0", res, z, c, v);
        else passed++;
        do_op(1'b1, 32'h8000_0000, 32'h0000_0001, OP_SUB, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1})
            $display("FAIL d4_sub_ovf got res=%h z=%b c=%b v=%b want res=7fffffff z=0 c=1 v=1",
                     res, z, c, v);
        else passed++;
        do_op(1'b1, 32'h0000_00F0, 32'h0000_0F00, OP_OR, -1, res, z, c, v, lat);
        total++;
        if (res !== 32'h0000_0FF0) $display("FAIL d4_or got res=%h want 00000ff0", res);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic z, c, v; int lat;
        do_op(1'b1, 32'hDEAD_BEEF, 32'hFFFF_0000, OP_AND, 3, res, z, c, v, lat);
        total++;
        if (lat != 9) $display("FAIL b2b_latency got %0d want 9", lat);
        else passed++;
        total++;
        if ({res, z, c, v} !== {32'hDEAD_0000, 1'b0, 1'b0, 1'b0})
            $display("FAIL b2b_result got res=%h z=%b c=%b v=%b want res=dead0000 z=0 c=0 v=0",
                     res, z, c, v);
        else passed++;
        // start during the done cycle must also be ignored
        s4_start = 1'b1;
        s4_a = 32'h0; s4_b = 32'h0; s4_op = OP_OR;
        @(negedge clk);
        s4_start = 1'b0;
        total++;
        if ({s4_busy, s4_done, s4_res} !== {1'b0, 1'b0, 32'hDEAD_0000})
            $display("FAIL b2b_done_start got busy=%b done=%b res=%h want busy=0 done=0 res=dead0000",
                     s4_busy, s4_done, s4_res);
        else passed++;
        @(negedge clk);
        total++;
        if ({s4_busy, s4_done} !== 2'b00)
            $display("FAIL b2b_idle got busy=%b done=%b want 0 0", s4_busy, s4_done);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic z, c, v; int lat;
        logic seen_done;
        @(negedge clk);
        s1_start = 1'b1; s1_a = 32'h1234_5678; s1_b = 32'h0F0F_0F0F; s1_op = OP_ADD;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            s1_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({s1_busy, s1_done, s1_res, s1_zero, s1_cout, s1_ovf} !== 37'h0)
            $display("FAIL mid_reset got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                     s1_busy, s1_done, s1_res, s1_zero, s1_cout, s1_ovf);
        else passed++;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (s1_done !== 1'b0) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s1_done !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) $display("FAIL mid_reset_no_done got done seen=%b want 0", seen_done);
        else passed++;
        do_op(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, OP_ADD, -1, res, z, c, v, lat);
        total++;
        if ({res, z, c, v} !== {32'h2143_6587, 1'b0, 1'b0, 1'b0} || lat != 33)
            $display("FAIL mid_reset_fresh got res=%h z=%b c=%b v=%b lat=%0d want res=21436587 flags 0 lat=33",
                     res, z, c, v, lat);
        else passed++;
    endtask

`ifdef ALU_SERIAL_ABORT_EN
    task automatic test_abort();
        logic seen_done;
        @(negedge clk);
        s1_start = 1'b1; s1_a = 32'h1234_5678; s1_b = 32'h0F0F_0F0F; s1_op = OP_ADD;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            s1_start = 1'b0;
        end
        s1_abort = 1'b1;
        s1_start = 1'b1;
        @(negedge clk);
        s1_abort = 1'b0;
        s1_start = 1'b0;
        total++;
        if ({s1_busy, s1_done, s1_res, s1_zero, s1_cout, s1_ovf} !== 37'h0)
            $display("FAIL abort got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                     s1_busy, s1_done, s1_res, s1_zero, s1_cout, s1_ovf);
        else passed++;
        seen_done = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (s1_done !== 1'b0 || s1_busy !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) $display("FAIL abort_quiet got activity=%b want 0", seen_done);
        else passed++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_op = '0;
        s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_op = '0;
`ifdef ALU_SERIAL_ABORT_EN
        s1_abort = 1'b0;
        s4_abort = 1'b0;
`endif
        busy_at1 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_add();
        test_sub_nor();
        test_slt();
        test_bad_code();
        test_digit4();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_SERIAL_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
